// File: rtl/sprite_layer_arbiter_if.sv
// Bundle of scan, table-write, shared-ROM and pixel-output signals for sprite_layer_arbiter.
// master = scan/CPU/ROM side, slave = the arbiter itself.
interface sprite_layer_arbiter_if #(
    parameter int NUM_OBJ = 4,
    parameter int ADDR_W  = 11
);
    localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              frame_start;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [9:0]        wr_x;
    logic [9:0]        wr_y;
    logic [ADDR_W-1:0] wr_base;
    logic              wr_vis;
    logic              wr_flip;
    logic [ADDR_W-1:0] rom_address;
    logic [6:0]        rom_q;
    logic [6:0]        pixel_idx;
    logic              pixel_on;
    logic              collide;

    modport master (
        output DrawX, DrawY, frame_start,
        output wr_en, wr_idx, wr_x, wr_y, wr_base, wr_vis, wr_flip,
        output rom_q,
        input  rom_address, pixel_idx, pixel_on, collide
    );

    modport slave (
        input  DrawX, DrawY, frame_start,
        input  wr_en, wr_idx, wr_x, wr_y, wr_base, wr_vis, wr_flip,
        input  rom_q,
        output rom_address, pixel_idx, pixel_on, collide
    );
endinterface

// File: rtl/sprite_layer_arbiter.sv
// Per-pixel arbiter sharing one sprite ROM among NUM_OBJ objects, with a 3-cycle pixel pipeline.
// Define SPRITE_FLIP_EN to add per-slot horizontal mirroring.
module sprite_layer_arbiter #(
    parameter int NUM_OBJ     = 4,
    parameter int SPRITE_SIZE = 15,
    parameter int ADDR_W      = 11
) (
    input  logic                  vga_clk,
    input  logic                  Reset,
    sprite_layer_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    logic [NUM_OBJ-1:0]             hit;
    logic [NUM_OBJ-1:0][ADDR_W-1:0] addr_slot;

    generate
        for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_slot
            logic [9:0]        sh_x_reg, sh_y_reg, act_x_reg, act_y_reg;
            logic [ADDR_W-1:0] sh_base_reg, act_base_reg;
            logic              sh_vis_reg, act_vis_reg;
            logic [9:0]        dist_x, dist_y, col;
`ifdef SPRITE_FLIP_EN
            logic              sh_flip_reg, act_flip_reg;
`endif

            // Shadow takes CPU writes; active copies the pre-write shadow on frame_start.
            always_ff @(posedge vga_clk or posedge Reset) begin
                if (Reset) begin
                    sh_x_reg     <= '0;
                    sh_y_reg     <= '0;
                    sh_base_reg  <= '0;
                    sh_vis_reg   <= 1'b0;
                    act_x_reg    <= '0;
                    act_y_reg    <= '0;
                    act_base_reg <= '0;
                    act_vis_reg  <= 1'b0;
`ifdef SPRITE_FLIP_EN
                    sh_flip_reg  <= 1'b0;
                    act_flip_reg <= 1'b0;
`endif
                end else begin
                    if (bus.wr_en && bus.wr_idx == IDX_W'(gi)) begin
                        sh_x_reg    <= bus.wr_x;
                        sh_y_reg    <= bus.wr_y;
                        sh_base_reg <= bus.wr_base;
                        sh_vis_reg  <= bus.wr_vis;
`ifdef SPRITE_FLIP_EN
                        sh_flip_reg <= bus.wr_flip;
`endif
                    end
                    if (bus.frame_start) begin
                        act_x_reg    <= sh_x_reg;
                        act_y_reg    <= sh_y_reg;
                        act_base_reg <= sh_base_reg;
                        act_vis_reg  <= sh_vis_reg;
`ifdef SPRITE_FLIP_EN
                        act_flip_reg <= sh_flip_reg;
`endif
                    end
                end
            end

            // Unsigned wrap makes boxes crossing the left/top edge simply miss.
            assign dist_x = bus.DrawX - act_x_reg;
            assign dist_y = bus.DrawY - act_y_reg;
            assign hit[gi] = act_vis_reg && (dist_x < 10'(SPRITE_SIZE)) && (dist_y < 10'(SPRITE_SIZE));

`ifdef SPRITE_FLIP_EN
            assign col = act_flip_reg ? (10'(SPRITE_SIZE - 1) - dist_x) : dist_x;
`else
            assign col = dist_x;
`endif
            assign addr_slot[gi] = act_base_reg
                                 + ADDR_W'(dist_y) * ADDR_W'(SPRITE_SIZE)
                                 + ADDR_W'(col);
        end
    endgenerate

`ifndef SPRITE_FLIP_EN
    logic unused_flip;
    assign unused_flip = bus.wr_flip;
`endif

    logic              sel_hit;
    logic [ADDR_W-1:0] sel_addr;

    // Scan from lowest priority up so the lowest-indexed hitting slot is written last.
    always_comb begin
        sel_hit  = 1'b0;
        sel_addr = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_hit  = 1'b1;
                sel_addr = addr_slot[i];
            end
        end
    end

    logic              hit_s1_reg, hit_s2_reg;
    logic [ADDR_W-1:0] rom_address_reg;
    logic              pixel_on_reg;
    logic [6:0]        pixel_idx_reg;
    logic              pixel_on_next;

    assign pixel_on_next = hit_s2_reg && (bus.rom_q != 7'd0);

    // Stage 1 drives the ROM, stage 2 waits for its registered read, stage 3 qualifies the index.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            hit_s1_reg      <= 1'b0;
            rom_address_reg <= '0;
            hit_s2_reg      <= 1'b0;
            pixel_on_reg    <= 1'b0;
            pixel_idx_reg   <= '0;
        end else begin
            hit_s1_reg      <= sel_hit;
            rom_address_reg <= sel_addr;
            hit_s2_reg      <= hit_s1_reg;
            pixel_on_reg    <= pixel_on_next;
            pixel_idx_reg   <= pixel_on_next ? bus.rom_q : 7'd0;
        end
    end

    logic coincide;
    logic collide_acc_reg, collide_reg;

    generate
        if (NUM_OBJ > 1) begin : g_coll
            assign coincide = hit[0] && (|hit[NUM_OBJ-1:1]);
        end else begin : g_no_coll
            assign coincide = 1'b0;
        end
    endgenerate

    // A coincidence seen in the frame_start cycle seeds the next frame's accumulator.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            collide_acc_reg <= 1'b0;
            collide_reg     <= 1'b0;
        end else if (bus.frame_start) begin
            collide_reg     <= collide_acc_reg;
            collide_acc_reg <= coincide;
        end else begin
            collide_acc_reg <= collide_acc_reg | coincide;
        end
    end

    assign bus.rom_address = rom_address_reg;
    assign bus.pixel_on    = pixel_on_reg;
    assign bus.pixel_idx   = pixel_idx_reg;
    assign bus.collide     = collide_reg;
endmodule
